spi_sclk_generator: RTL

Downstream of the SPI configuration stage: consumes its latched mode bits and initialization pulses, and generates the serial clock (SCLK) for one transfer of 1–32 bits. Produces one-cycle update and sample strobes aligned to SCLK edges for the shift-register datapath. Runs on the system clock, gated by `clk_en`, with a programmable half-period divider.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_half_period_counter.sv | 27 ++
 rtl/spi_sclk_generator.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI types and constants for the SCLK generator and chip-select timing stages.
package spi_pkg;

    localparam int SPI_MAX_BITS        = 32;
    localparam int SPI_BIT_COUNT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        RUN      = 2'd2,
        FINISH   = 2'd3
    } spi_sclk_state_t;

    // Even edges update when update_on_first_edge is set, odd edges otherwise.
    function automatic logic spi_is_update_edge(input logic edge_lsb, input logic update_on_first_edge);
        return edge_lsb ^ update_on_first_edge;
    endfunction

endpackage

// File: rtl/spi_half_period_counter.sv
// Reloadable half-period down-counter; o_expire marks an enabled cycle with the count at zero.
module spi_half_period_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             sync_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_expire
);

    logic [WIDTH-1:0] r_count;

    assign o_expire = i_enable && (r_count == '0);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/spi_sclk_generator.sv
// SPI serial clock generator: SCLK, update/sample strobes and done for one 1..32-bit transfer.
// Defining SPI_SCLK_GEN_STALL_EN adds a stall input that freezes RUN/FINISH progress.
module spi_sclk_generator
    import spi_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           clk_en,
    input  logic                           sync_rst,
    input  logic                           cpol,
    input  logic                           sclk_start_polarity,
    input  logic                           preamble_required,
    input  logic                           update_on_first_edge,
    input  logic                           initialize_out_going_trigger,
    input  logic [DIV_WIDTH-1:0]           half_period,
    input  logic [SPI_BIT_COUNT_WIDTH-1:0] bit_count,
    input  logic                           start,
`ifdef SPI_SCLK_GEN_STALL_EN
    input  logic                           stall,
`endif
    output logic                           sclk,
    output logic                           update_strobe,
    output logic                           sample_strobe,
    output logic                           busy,
    output logic                           done,
    output logic                           configured,
    output logic [1:0]                     dbg_state
);

    localparam int EDGE_WIDTH = $clog2(2 * SPI_MAX_BITS);

    spi_sclk_state_t                r_state;
    logic                           r_sclk;
    logic                           r_update;
    logic                           r_sample;
    logic                           r_done;
    logic                           r_configured;
    logic                           r_idle_level;
    logic [DIV_WIDTH-1:0]           r_half_period;
    logic [SPI_BIT_COUNT_WIDTH-1:0] r_bit_count;
    logic [EDGE_WIDTH-1:0]          r_edge;

    logic                           w_hold;
    logic                           w_tick;
    logic                           w_accept;
    logic                           w_expire;
    logic                           w_load;
    logic                           w_last_edge;
    logic                           w_update_edge;
    logic [DIV_WIDTH-1:0]           w_load_value;

`ifdef SPI_SCLK_GEN_STALL_EN
    assign w_hold = stall && ((r_state == RUN) || (r_state == FINISH));
`else
    assign w_hold = 1'b0;
`endif

    assign w_tick = clk_en && !w_hold && !initialize_out_going_trigger && (r_state != IDLE);

    // A start coinciding with the visible done pulse is deliberately dropped.
    assign w_accept = clk_en && !initialize_out_going_trigger && (r_state == IDLE)
                      && r_configured && start && !r_done;

    assign w_load        = w_accept || w_expire;
    assign w_load_value  = w_accept ? half_period : r_half_period;
    assign w_last_edge   = (r_edge == {r_bit_count, 1'b1});
    assign w_update_edge = spi_is_update_edge(r_edge[0], update_on_first_edge);

    spi_half_period_counter #(
        .WIDTH (DIV_WIDTH)
    ) u_half_period_counter (
        .clk          (clk),
        .sync_rst     (sync_rst),
        .i_load       (w_load),
        .i_load_value (w_load_value),
        .i_enable     (w_tick),
        .o_expire     (w_expire)
    );

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state       <= IDLE;
            r_sclk        <= 1'b0;
            r_update      <= 1'b0;
            r_sample      <= 1'b0;
            r_done        <= 1'b0;
            r_configured  <= 1'b0;
            r_idle_level  <= 1'b0;
            r_half_period <= '0;
            r_bit_count   <= '0;
            r_edge        <= '0;
        end else if (clk_en) begin
            r_update <= 1'b0;
            r_sample <= 1'b0;
            r_done   <= 1'b0;
            if (initialize_out_going_trigger) begin
                r_configured <= 1'b1;
                r_idle_level <= cpol;
                r_sclk       <= cpol;
                r_state      <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_half_period <= half_period;
                            r_bit_count   <= bit_count;
                            r_sclk        <= sclk_start_polarity;
                            r_edge        <= '0;
                            r_update      <= preamble_required;
                            r_state       <= preamble_required ? PREAMBLE : RUN;
                        end
                    end
                    PREAMBLE: begin
                        if (w_expire) r_state <= RUN;
                    end
                    RUN: begin
                        if (w_expire) begin
                            r_sclk <= ~r_sclk;
                            r_edge <= r_edge + 1'b1;
                            if (w_update_edge) r_update <= !w_last_edge;
                            else               r_sample <= 1'b1;
                            if (w_last_edge) r_state <= FINISH;
                        end
                    end
                    FINISH: begin
                        if (w_expire) begin
                            r_sclk  <= r_idle_level;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Pulses held across disabled cycles surface on the next enabled cycle.
    assign update_strobe = r_update && clk_en;
    assign sample_strobe = r_sample && clk_en;
    assign done          = r_done && clk_en;
    assign sclk          = r_sclk;
    assign busy          = (r_state != IDLE);
    assign configured    = r_configured;
    assign dbg_state     = r_state;

endmodule
